mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline register for the RISC-V core; sits between the data-memory stage and register-file writeback.
- Aligns and extends load data using the address byte offset, with XLEN-wide datapath support (32 or 64).
- Supports variable-latency data-memory responses through a wait state machine that stalls upstream stages.
- Provides flush/stall control, a valid bit, misalignment detection and x0 write suppression.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- OFF_W, $clog2(XLEN/8), byte-offset width; derived, not overridable.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- valid_mem  in  1  MEM-stage instruction valid
- wb_en_mem  in  1  instruction writes rd
- is_load_mem  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110 LWU, 111 LD
- rd_addr_mem  in  REG_AW  destination register
- alu_out_mem  in  XLEN  ALU result / load address
- dm_rsp_valid  in  1  data-memory read response valid
- dm_rdata  in  XLEN  data-memory read word, naturally aligned
- stall_i  in  1  hazard-unit freeze of WB registers
- flush_i  in  1  squash the MEM-stage instruction
- mem_stall_o  out  1  combinational request to freeze IF..MEM
- valid_wb  out  1  WB instruction valid
- wb_en_wb  out  1  register-file write enable
- rd_addr_wb  out  REG_AW  WB destination
- wb_data_wb  out  XLEN  writeback data, also the forwarding source
- misalign_wb  out  1  load-misaligned exception flag, qualified by valid_wb

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE. mem_stall_o is 0 while in reset.
- Load alignment:
  - off = alu_out_mem[OFF_W-1:0]; the raw value is dm_rdata >> (off*8).
  - LB/LH/LW sign-extend bit 7/15/31 to XLEN. LBU/LHU/LWU zero-extend. LD passes the raw value.
  - Non-load (000): wb_data = alu_out_mem.
- XLEN=32 encodings:
  - 110 behaves as LW.
  - 111 raises misalign and suppresses the write.
- Misalignment:
  - Conditions: LH/LHU with off[0]=1; LW/LWU with off[1:0]≠0; LD with off[2:0]≠0.
  - Result: misalign_wb=1, wb_en_wb=0, valid_wb=1, wb_data_wb=0.
- Write enable: wb_en_wb = valid & wb_en_mem & (rd_addr_mem≠0) & !misalign.
- States:
  - IDLE:
    - Non-load or load with dm_rsp_valid=1: outputs register at next edge (latency 1).
    - Valid load with dm_rsp_valid=0: mem_stall_o=1, go to WAIT, WB registers load a bubble (valid_wb=0, wb_en_wb=0).
  - WAIT:
    - mem_stall_o = !dm_rsp_valid; upstream holds its inputs stable.
    - Bubble is held each cycle until dm_rsp_valid=1.
    - On response: capture the aligned load result and return to IDLE.
  - DISCARD:
    - Entered on flush_i while in WAIT.
    - mem_stall_o=1 until the orphan dm_rsp_valid arrives; the response is dropped, then IDLE.
    - Output is a bubble throughout.
- Priority at each edge: rst > flush_i > WAIT/DISCARD response handling > stall_i > normal capture.
- flush_i:
  - In IDLE: load a bubble; the state stays IDLE even if the instruction was a load.
  - Simultaneous with dm_rsp_valid in WAIT: drop the data, go to IDLE (not DISCARD).
- stall_i: honoured only in IDLE; all WB registers hold and no state change occurs. In WAIT/DISCARD it is ignored, because mem_stall_o already freezes upstream.
- Instruction with valid_mem=0: treated as a bubble, no state change.
- Reset mid-WAIT: returns to IDLE immediately; an in-flight response is the memory's responsibility.

Decomposition:
- Package core_pkg:
  - load_type_e enum (the 3-bit encodings above)
  - mwb_state_e {IDLE, WAIT, DISCARD}
  - constant BUBBLE for the cleared WB bundle
- Sub-module load_align_ext: purely combinational (is_load, off, rdata → data, misalign), parametrised by XLEN.
- mem_wb_pipe holds the FSM and registers.

Test Plan:
- XLEN=32. LB, off=2, dm_rdata=0x80FF_1234, rsp same cycle → next cycle wb_data_wb=0xFFFF_FFFF, wb_en_wb=1, mem_stall_o never asserted.
- XLEN=32. LHU, off=2, dm_rdata=0x8001_0000, rsp 3 cycles late → mem_stall_o high 3 cycles, valid_wb=0 during wait, then wb_data_wb=0x0000_8001.
- XLEN=32. LW, alu_out=0x1002 → misalign_wb=1, wb_en_wb=0, valid_wb=1, wb_data_wb=0.
- ALU op, rd=0, alu_out=0x55 → valid_wb=1, wb_en_wb=0, wb_data_wb=0x55. stall_i=1 on the next cycle → outputs held.
- Load enters WAIT, flush_i pulse, rsp 2 cycles later → DISCARD with mem_stall_o=1 until rsp, data dropped, valid_wb=0 throughout, then IDLE.
- XLEN=64. LWU, off=4, dm_rdata=0xF000_0001_0000_0000 → wb_data_wb=0x0000_0000_F000_0001. Assert rst mid-WAIT → all outputs 0, mem_stall_o=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the MEM/WB pipeline register.
//   load_type_e : 3-bit load encodings carried down from decode
//   mwb_state_e : MEM/WB response-wait FSM states
//   wb_ctrl_t   : control half of the WB bundle; BUBBLE is its cleared value
package core_pkg;

  typedef enum logic [2:0] {
    LdNone = 3'b000,
    LdB    = 3'b001,
    LdH    = 3'b010,
    LdW    = 3'b011,
    LdBu   = 3'b100,
    LdHu   = 3'b101,
    LdWu   = 3'b110,
    LdD    = 3'b111
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } mwb_state_e;

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic misalign;
  } wb_ctrl_t;

  localparam wb_ctrl_t BUBBLE = '{valid: 1'b0, wb_en: 1'b0, misalign: 1'b0};

endpackage

// File: rtl/load_align_ext.sv
// Combinational load aligner / extender.
//   is_load  : load type (core_pkg::load_type_e encoding)
//   off      : byte offset of the load address within the XLEN word
//   rdata    : naturally aligned data-memory read word
//   data     : shifted and sign/zero-extended result, 0 when misaligned
//   misalign : access is not naturally aligned (or LD on a 32-bit core)
module load_align_ext
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       is_load,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data,
  output logic             misalign
);

  logic [XLEN-1:0] raw;
  logic [2:0]      off3;

  assign raw  = rdata >> {off, 3'b000};
  assign off3 = 3'(off);

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    unique case (load_type_e'(is_load))
      LdNone: data = '0;
      LdB:    data = XLEN'($signed(raw[7:0]));
      LdBu:   data = XLEN'(raw[7:0]);
      LdH: begin
        misalign = off3[0];
        data     = XLEN'($signed(raw[15:0]));
      end
      LdHu: begin
        misalign = off3[0];
        data     = XLEN'(raw[15:0]);
      end
      LdW: begin
        misalign = (off3[1:0] != 2'b00);
        data     = XLEN'($signed(raw[31:0]));
      end
      LdWu: begin
        misalign = (off3[1:0] != 2'b00);
        // On a 32-bit core LWU is not a distinct op and acts as LW.
        if (XLEN == 32) data = XLEN'($signed(raw[31:0]));
        else            data = XLEN'(raw[31:0]);
      end
      LdD: begin
        if (XLEN == 64) begin
          misalign = (off3 != 3'b000);
          data     = raw;
        end else begin
          misalign = 1'b1;
        end
      end
      default: data = '0;
    endcase
    if (misalign) data = '0;
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with load alignment and variable-latency memory wait.
//   clk, rst                 : clock, async active-high reset
//   valid_mem .. alu_out_mem : MEM-stage instruction bundle
//   dm_rsp_valid, dm_rdata   : data-memory read response
//   stall_i, flush_i         : hazard-unit freeze / squash
//   mem_stall_o              : combinational freeze request for IF..MEM
//   valid_wb .. misalign_wb  : registered WB bundle (wb_data_wb is also the forwarding source)
module mem_wb_pipe
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_mem,
  input  logic              wb_en_mem,
  input  logic [2:0]        is_load_mem,
  input  logic [REG_AW-1:0] rd_addr_mem,
  input  logic [XLEN-1:0]   alu_out_mem,
  input  logic              dm_rsp_valid,
  input  logic [XLEN-1:0]   dm_rdata,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_stall_o,
  output logic              valid_wb,
  output logic              wb_en_wb,
  output logic [REG_AW-1:0] rd_addr_wb,
  output logic [XLEN-1:0]   wb_data_wb,
  output logic              misalign_wb
);

  mwb_state_e        state_q, state_d;
  wb_ctrl_t          ctrl_q, ctrl_d, cap_ctrl;
  logic [REG_AW-1:0] rd_q, rd_d, cap_rd;
  logic [XLEN-1:0]   data_q, data_d, cap_data;
  logic [XLEN-1:0]   al_data;
  logic              al_mis;
  logic              load_op;
  logic              upd;
  logic              stall_req;

  load_align_ext #(
    .XLEN(XLEN)
  ) u_align (
    .is_load (is_load_mem),
    .off     (alu_out_mem[OFF_W-1:0]),
    .rdata   (dm_rdata),
    .data    (al_data),
    .misalign(al_mis)
  );

  assign load_op = (is_load_mem != LdNone);

  // What the WB registers take when the MEM-stage instruction completes.
  always_comb begin
    cap_ctrl.valid    = valid_mem;
    cap_ctrl.misalign = valid_mem & load_op & al_mis;
    cap_ctrl.wb_en    = valid_mem & wb_en_mem & (rd_addr_mem != '0) & ~(load_op & al_mis);
    cap_rd            = valid_mem ? rd_addr_mem : '0;
    if (!valid_mem)   cap_data = '0;
    else if (load_op) cap_data = al_data;
    else              cap_data = alu_out_mem;
  end

  always_comb begin
    state_d   = state_q;
    upd       = 1'b1;
    ctrl_d    = BUBBLE;
    rd_d      = '0;
    data_d    = '0;
    stall_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (stall_i) begin
          upd = 1'b0;
        end else if (valid_mem && load_op && !dm_rsp_valid) begin
          stall_req = 1'b1;
          state_d   = WAIT;
        end else begin
          ctrl_d = cap_ctrl;
          rd_d   = cap_rd;
          data_d = cap_data;
        end
      end
      WAIT: begin
        stall_req = ~dm_rsp_valid;
        if (flush_i) begin
          // A response arriving with the flush is simply dropped; nothing left in flight.
          state_d = dm_rsp_valid ? IDLE : DISCARD;
        end else if (dm_rsp_valid) begin
          ctrl_d  = cap_ctrl;
          rd_d    = cap_rd;
          data_d  = cap_data;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        // Hold upstream through the orphan response so it cannot be taken
        // as the reply to a younger load.
        stall_req = 1'b1;
        if (dm_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall_o = stall_req & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= BUBBLE;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (upd) begin
        ctrl_q <= ctrl_d;
        rd_q   <= rd_d;
        data_q <= data_d;
      end
    end
  end

  assign valid_wb    = ctrl_q.valid;
  assign wb_en_wb    = ctrl_q.wb_en;
  assign misalign_wb = ctrl_q.misalign;
  assign rd_addr_wb  = rd_q;
  assign wb_data_wb  = data_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // XLEN=32 instance
  logic        rst, valid_mem, wb_en_mem, rsp, stall, flush;
  logic [2:0]  ld;
  logic [4:0]  rd;
  logic [31:0] alu, rdata;
  logic        mstall, v_wb, we_wb, mis_wb;
  logic [4:0]  rd_wb;
  logic [31:0] d_wb;

  mem_wb_pipe #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .wb_en_mem(wb_en_mem),
    .is_load_mem(ld), .rd_addr_mem(rd), .alu_out_mem(alu), .dm_rsp_valid(rsp),
    .dm_rdata(rdata), .stall_i(stall), .flush_i(flush), .mem_stall_o(mstall),
    .valid_wb(v_wb), .wb_en_wb(we_wb), .rd_addr_wb(rd_wb), .wb_data_wb(d_wb),
    .misalign_wb(mis_wb)
  );

  // XLEN=64 instance
  logic        rst64, valid64, we64, rsp64, stall64, flush64;
  logic [2:0]  ld64;
  logic [4:0]  rd64;
  logic [63:0] alu64, rdata64;
  logic        mstall64, v_wb64, we_wb64, mis_wb64;
  logic [4:0]  rd_wb64;
  logic [63:0] d_wb64;

  mem_wb_pipe #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst64), .valid_mem(valid64), .wb_en_mem(we64),
    .is_load_mem(ld64), .rd_addr_mem(rd64), .alu_out_mem(alu64), .dm_rsp_valid(rsp64),
    .dm_rdata(rdata64), .stall_i(stall64), .flush_i(flush64), .mem_stall_o(mstall64),
    .valid_wb(v_wb64), .wb_en_wb(we_wb64), .rd_addr_wb(rd_wb64), .wb_data_wb(d_wb64),
    .misalign_wb(mis_wb64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] l, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] rdat, input logic rv,
                       input logic st, input logic fl);
    valid_mem = v; wb_en_mem = we; ld = l; rd = r; alu = a; rdata = rdat; rsp = rv;
    stall = st; flush = fl;
  endtask

  typedef struct {
    logic        v;
    logic        we;
    logic [2:0]  l;
    logic [4:0]  r;
    logic [31:0] a;
    logic [31:0] rdat;
    logic        e_v;
    logic        e_we;
    logic        e_mis;
    logic [31:0] e_d;
  } vec_t;

  vec_t vecs[12];
  int   nstall;

  initial begin
    // Single-cycle vectors, response always present
    vecs[0]  = '{1, 1, 3'b001, 5, 32'h0000_1002, 32'h80FF_1234, 1, 1, 0, 32'hFFFF_FFFF};
    vecs[1]  = '{1, 1, 3'b011, 6, 32'h0000_1002, 32'h1111_2222, 1, 0, 1, 32'h0000_0000};
    vecs[2]  = '{1, 1, 3'b000, 0, 32'h0000_0055, 32'h0000_0000, 1, 0, 0, 32'h0000_0055};
    vecs[3]  = '{1, 1, 3'b100, 7, 32'h0000_0003, 32'h80FF_1234, 1, 1, 0, 32'h0000_0080};
    vecs[4]  = '{1, 1, 3'b010, 8, 32'h0000_0000, 32'h1234_8001, 1, 1, 0, 32'hFFFF_8001};
    vecs[5]  = '{1, 1, 3'b101, 9, 32'h0000_0001, 32'h1234_8001, 1, 0, 1, 32'h0000_0000};
    vecs[6]  = '{1, 1, 3'b011, 10, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1, 0, 32'hDEAD_BEEF};
    vecs[7]  = '{1, 1, 3'b110, 11, 32'h0000_0000, 32'h8000_0000, 1, 1, 0, 32'h8000_0000};
    vecs[8]  = '{1, 1, 3'b111, 12, 32'h0000_0000, 32'h1234_5678, 1, 0, 1, 32'h0000_0000};
    vecs[9]  = '{0, 1, 3'b011, 13, 32'h0000_0000, 32'h1234_5678, 0, 0, 0, 32'h0000_0000};
    vecs[10] = '{1, 0, 3'b000, 3, 32'h0000_1234, 32'h0000_0000, 1, 0, 0, 32'h0000_1234};
    vecs[11] = '{1, 1, 3'b010, 14, 32'h0000_0002, 32'h7FFF_0000, 1, 1, 0, 32'h0000_7FFF};

    drive(1, 1, 3'b011, 5, 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b1;
    rst64 = 1'b1; valid64 = 0; we64 = 0; ld64 = 0; rd64 = 0; alu64 = 0; rdata64 = 0;
    rsp64 = 0; stall64 = 0; flush64 = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {63'd0, mstall}, 64'd0);
    chk("rst_valid", {63'd0, v_wb}, 64'd0);
    chk("rst_data", {32'd0, d_wb}, 64'd0);
    rst = 1'b0; rst64 = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].we, vecs[i].l, vecs[i].r, vecs[i].a, vecs[i].rdat, 1, 0, 0);
      #1;
      chk($sformatf("v%0d_stall", i), {63'd0, mstall}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {63'd0, v_wb}, {63'd0, vecs[i].e_v});
      chk($sformatf("v%0d_wben", i), {63'd0, we_wb}, {63'd0, vecs[i].e_we});
      chk($sformatf("v%0d_mis", i), {63'd0, mis_wb}, {63'd0, vecs[i].e_mis});
      chk($sformatf("v%0d_data", i), {32'd0, d_wb}, {32'd0, vecs[i].e_d});
      if (vecs[i].e_we) chk($sformatf("v%0d_rd", i), {59'd0, rd_wb}, {59'd0, vecs[i].r});
    end

    // ALU op to x0, then stall_i holds the WB registers against new inputs
    @(negedge clk); drive(1, 1, 3'b000, 0, 32'h55, 32'h0, 1, 0, 0);
    @(posedge clk); #1;
    @(negedge clk); drive(1, 1, 3'b000, 7, 32'h99, 32'h0, 1, 1, 0);
    @(posedge clk); #1;
    chk("stall_valid", {63'd0, v_wb}, 64'd1);
    chk("stall_wben", {63'd0, we_wb}, 64'd0);
    chk("stall_data", {32'd0, d_wb}, 64'h55);

    // LHU off=2 with response three cycles late
    nstall = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(1, 1, 3'b101, 9, 32'h2002, 32'h0, 0, 0, 0);
      #1; if (mstall) nstall++;
      @(posedge clk); #1;
      chk($sformatf("wait%0d_valid", c), {63'd0, v_wb}, 64'd0);
    end
    @(negedge clk); drive(1, 1, 3'b101, 9, 32'h2002, 32'h8001_0000, 1, 0, 0);
    #1; if (mstall) nstall++;
    @(posedge clk); #1;
    chk("lhu_stall_cycles", 64'(nstall), 64'd3);
    chk("lhu_valid", {63'd0, v_wb}, 64'd1);
    chk("lhu_wben", {63'd0, we_wb}, 64'd1);
    chk("lhu_data", {32'd0, d_wb}, 64'h0000_8001);

    // Flush while waiting: orphan response arrives two cycles later and is dropped
    @(negedge clk); drive(1, 1, 3'b011, 4, 32'h40, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk); drive(1, 1, 3'b011, 4, 32'h40, 32'h0, 0, 0, 1);
    #1; chk("fl_wait_stall", {63'd0, mstall}, 64'd1);
    @(posedge clk); #1;
    chk("fl_valid0", {63'd0, v_wb}, 64'd0);
    @(negedge clk); drive(1, 1, 3'b000, 6, 32'h77, 32'h0, 0, 0, 0);
    #1; chk("disc_stall", {63'd0, mstall}, 64'd1);
    @(posedge clk); #1;
    chk("disc_valid1", {63'd0, v_wb}, 64'd0);
    @(negedge clk); drive(1, 1, 3'b000, 6, 32'h77, 32'hCAFE_F00D, 1, 0, 0);
    @(posedge clk); #1;
    chk("disc_valid2", {63'd0, v_wb}, 64'd0);
    chk("disc_data", {32'd0, d_wb}, 64'd0);
    @(negedge clk); drive(1, 1, 3'b000, 6, 32'h77, 32'h0, 0, 0, 0);
    #1; chk("post_disc_stall", {63'd0, mstall}, 64'd0);
    @(posedge clk); #1;
    chk("post_disc_data", {32'd0, d_wb}, 64'h77);
    chk("post_disc_wben", {63'd0, we_wb}, 64'd1);

    // Flush in IDLE of a pending load: bubble, and the state stays IDLE
    @(negedge clk); drive(1, 1, 3'b011, 4, 32'h40, 32'h0, 0, 0, 1);
    @(posedge clk); #1;
    chk("fl_idle_valid", {63'd0, v_wb}, 64'd0);
    @(negedge clk); drive(1, 1, 3'b000, 2, 32'h33, 32'h0, 0, 0, 0);
    #1; chk("fl_idle_stall", {63'd0, mstall}, 64'd0);
    @(posedge clk); #1;
    chk("fl_idle_next", {32'd0, d_wb}, 64'h33);

    // Asynchronous reset clears populated outputs mid-cycle
    @(negedge clk); rst = 1'b1; #1;
    chk("arst_valid", {63'd0, v_wb}, 64'd0);
    chk("arst_data", {32'd0, d_wb}, 64'd0);
    rst = 1'b0;

    // XLEN=64: LWU off=4, then a pending LD reset mid-WAIT
    @(negedge clk);
    valid64 = 1; we64 = 1; ld64 = 3'b110; rd64 = 21; alu64 = 64'h104;
    rdata64 = 64'hF000_0001_0000_0000; rsp64 = 1;
    @(posedge clk); #1;
    chk("lwu64_data", d_wb64, 64'h0000_0000_F000_0001);
    chk("lwu64_wben", {63'd0, we_wb64}, 64'd1);
    @(negedge clk);
    ld64 = 3'b011; alu64 = 64'h104; rdata64 = 64'h8000_0000_0000_0000;
    @(posedge clk); #1;
    chk("lw64_data", d_wb64, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    ld64 = 3'b111; alu64 = 64'h200; rsp64 = 0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("ld64_wait_stall", {63'd0, mstall64}, 64'd1);
    rst64 = 1'b1; #1;
    chk("rst64_stall", {63'd0, mstall64}, 64'd0);
    chk("rst64_valid", {63'd0, v_wb64}, 64'd0);
    chk("rst64_data", d_wb64, 64'd0);
    chk("rst64_rd", {59'd0, rd_wb64}, 64'd0);
    @(posedge clk); #1;
    rst64 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
